hazard_fwd_unit: RTL

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

---
 rtl/hazard_fwd_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding from p3-4/p4-5/p5-2 into p3, plus load-use stall control.
// Latency: fwd_data is combinational; stall asserts in the hazard cycle and lasts LOAD_LAT cycles.
// Backpressure: stall holds PC/p2 and bubbles p3; flush cancels any stall in progress.
module hazard_fwd_unit #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int NUM_SRC        = 2,
  parameter int LOAD_LAT       = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 RST,
  input  logic                                 flush,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]    src_addr,
  input  logic [NUM_SRC-1:0]                   src_used,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]        src_data_p2,
  input  logic                                 wr_en_p34,
  input  logic                                 wr_en_p45,
  input  logic                                 wr_en_p52,
  input  logic [REG_ADDR_WIDTH-1:0]            wr_addr_p34,
  input  logic [REG_ADDR_WIDTH-1:0]            wr_addr_p45,
  input  logic [REG_ADDR_WIDTH-1:0]            wr_addr_p52,
  input  logic signed [DATA_WIDTH-1:0]         wr_data_p34,
  input  logic signed [DATA_WIDTH-1:0]         wr_data_p45,
  input  logic signed [DATA_WIDTH-1:0]         wr_data_p52,
  input  logic                                 is_load_p34,
  output logic signed [NUM_SRC*DATA_WIDTH-1:0] fwd_data,
  output logic                                 stall,
  output logic [CNT_WIDTH-1:0]                 stall_count
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [NUM_SRC-1:0]    m34;
  logic                  hazard;
  logic                  stall_c;

  // Per-port bypass mux: youngest matching producer wins; a pending load in p3-4 is skipped.
  always_comb begin
    logic [REG_ADDR_WIDTH-1:0] a;
    logic                      nz;
    fwd_data = src_data_p2;
    m34      = '0;
    a        = '0;
    nz       = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      a      = src_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      nz     = (a != '0);
      m34[i] = wr_en_p34 && (wr_addr_p34 == a) && nz;
      if (m34[i] && !is_load_p34)
        fwd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data_p34;
      else if (wr_en_p45 && (wr_addr_p45 == a) && nz)
        fwd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data_p45;
      else if (wr_en_p52 && (wr_addr_p52 == a) && nz)
        fwd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data_p52;
    end
  end

  // Load-use hazard: only operands the instruction actually reads can stall it.
  assign hazard = is_load_p34 && |(m34 & src_used);

  // Stall FSM next-state: the hazard cycle itself is stall #1, STALL covers the remaining LOAD_LAT-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          stall_c = hazard;
          if (hazard && (LOAD_LAT > 1)) begin
            state_nxt = STALL;
            cnt_nxt   = LAT_M1;
          end
        end
        STALL: begin
          stall_c = 1'b1;
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1)
            state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Gate with reset so an in-flight hazard cannot assert stall while the unit is held in reset.
  assign stall = RST & stall_c;

  // FSM state and remaining-stall counter.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Saturating stall-cycle statistic; flush does not clear it.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end

endmodule
